tl_rx_read_handler_cpl_vc_arbiter: RTL

- Round-robin scheduler that shares the single RX read-handler completion controller between NUM_VC virtual-channel completion buffers.
- Selects one VC with a pending completion header and steers that VC's empty flags, fmt data bit and length field to the controller.
- Routes the controller's read-pointer control bus back to the granted VC only.
- Holds the grant until the completion's header is consumed, then inserts a one-cycle gap so the controller never sees stale flags.

---
 rtl/tl_rx_read_handler_cpl_vc_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/tl_rx_read_handler_cpl_vc_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tl_rx_read_handler_cpl_vc_arbiter
// Purpose  : Round-robin sharing of the RX read-handler completion controller
//            between NUM_VC virtual-channel completion buffers. Steers the
//            granted VC's head-completion info to the controller and returns
//            the controller's read-pointer control bus to that VC only.
// Revision : 1.0 - initial release
// ============================================================================
module tl_rx_read_handler_cpl_vc_arbiter #(
    parameter int NUM_VC           = 2,
    parameter int CPL_FLAGS_WIDTH  = 2,
    parameter int PAYLOAD_LENGTH   = 10,
    parameter int R_CTRL_BUS_WIDTH = 5
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic [NUM_VC*CPL_FLAGS_WIDTH-1:0]    i_vc_cpl_empty_flags,
    input  logic [NUM_VC-1:0]                    i_vc_cpl_fmt_data_bit,
    input  logic [NUM_VC*PAYLOAD_LENGTH-1:0]     i_vc_cpl_length_field,
    input  logic [R_CTRL_BUS_WIDTH-1:0]          i_r_completion_ctrl,
    output logic [CPL_FLAGS_WIDTH-1:0]           o_cpl_empty_flags,
    output logic                                 o_cpl_fmt_data_bit,
    output logic [PAYLOAD_LENGTH-1:0]            o_cpl_length_field,
    output logic [NUM_VC*R_CTRL_BUS_WIDTH-1:0]   o_vc_r_completion_ctrl,
    output logic [NUM_VC-1:0]                    o_grant,
    output logic                                 o_grant_valid
);

    localparam int PTR_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_granted = 2'd1;
    localparam logic [1:0] c_st_gap     = 2'd2;

    localparam logic [PTR_W-1:0] c_last_vc = PTR_W'(NUM_VC - 1);

    logic [1:0]        r_state;
    logic [PTR_W-1:0]  r_rr_ptr;
    logic [PTR_W-1:0]  r_grant_idx;
    logic [NUM_VC-1:0] r_grant;

    logic [NUM_VC-1:0] w_req;
    logic [PTR_W-1:0]  w_winner;
    logic [NUM_VC-1:0] w_winner_onehot;
    logic              w_granted;
    logic              w_hdr_inc;

    // First requester found scanning upward from ptr, wrapping at NUM_VC.
    function automatic logic [PTR_W-1:0] f_pick(input logic [NUM_VC-1:0] req,
                                                input logic [PTR_W-1:0]  ptr);
        logic [PTR_W-1:0] idx;
        logic             found;
        f_pick = ptr;
        found  = 1'b0;
        idx    = ptr;
        for (int i = 0; i < NUM_VC; i++) begin
            if (!found && req[idx]) begin
                found  = 1'b1;
                f_pick = idx;
            end
            idx = (idx == c_last_vc) ? '0 : idx + PTR_W'(1);
        end
    endfunction

    // A VC requests service only when its head header is present.
    always_comb begin
        w_req = '0;
        for (int k = 0; k < NUM_VC; k++) begin
            w_req[k] = ~i_vc_cpl_empty_flags[k*CPL_FLAGS_WIDTH + CPL_FLAGS_WIDTH - 1];
        end
    end

    // Round-robin winner and its one-hot form, used only to load the grant register.
    always_comb begin
        w_winner        = f_pick(w_req, r_rr_ptr);
        w_winner_onehot = '0;
        for (int k = 0; k < NUM_VC; k++) begin
            if (w_winner == PTR_W'(k)) begin
                w_winner_onehot[k] = 1'b1;
            end
        end
    end

    assign w_granted = (r_state == c_st_granted);
    assign w_hdr_inc = i_r_completion_ctrl[R_CTRL_BUS_WIDTH-1];

    // Arbitration FSM: IDLE arbitrates, GRANTED holds until hdr_inc, GAP lets buffer flags settle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= c_st_idle;
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
            r_grant     <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (|w_req) begin
                        r_state     <= c_st_granted;
                        r_grant_idx <= w_winner;
                        r_grant     <= w_winner_onehot;
                    end
                end
                c_st_granted: begin
                    if (w_hdr_inc) begin
                        r_state  <= c_st_gap;
                        r_grant  <= '0;
                        r_rr_ptr <= (r_grant_idx == c_last_vc) ? '0 : r_grant_idx + PTR_W'(1);
                    end
                end
                c_st_gap: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                    r_grant <= '0;
                end
            endcase
        end
    end

    // Head-completion mux, selected only by the registered grant; idle value otherwise.
    always_comb begin
        o_cpl_empty_flags  = '1;
        o_cpl_fmt_data_bit = 1'b0;
        o_cpl_length_field = '0;
        if (w_granted) begin
            for (int k = 0; k < NUM_VC; k++) begin
                if (r_grant_idx == PTR_W'(k)) begin
                    o_cpl_empty_flags  = i_vc_cpl_empty_flags[k*CPL_FLAGS_WIDTH +: CPL_FLAGS_WIDTH];
                    o_cpl_fmt_data_bit = i_vc_cpl_fmt_data_bit[k];
                    o_cpl_length_field = i_vc_cpl_length_field[k*PAYLOAD_LENGTH +: PAYLOAD_LENGTH];
                end
            end
        end
    end

    // Control bus goes back to the granted VC only; everything else sees zero.
    generate
        for (genvar k = 0; k < NUM_VC; k++) begin : g_ctrl_demux
            assign o_vc_r_completion_ctrl[k*R_CTRL_BUS_WIDTH +: R_CTRL_BUS_WIDTH] =
                (w_granted && r_grant[k]) ? i_r_completion_ctrl : '0;
        end
    endgenerate

    assign o_grant       = r_grant;
    assign o_grant_valid = w_granted;

endmodule
`default_nettype wire
